// File: rtl/dot_product_acc_if.sv
// Beat, control and result bundle of the dot-product engine.
// Timing and flow control are defined by the engine that drives the slave side.
interface dot_product_acc_if #(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int LANES       = 4
);
    logic                          start;
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*PIXEL_SIZE-1:0]   Pixels;
    logic [LANES*WEIGHT_SIZE-1:0]  Weights;
    logic                          out_valid;
    logic                          out_ready;
    logic [VAL_SIZE-1:0]           value;
    logic                          overflow;
    logic                          busy;

    modport master (
        output start, in_valid, Pixels, Weights, out_ready,
        input  in_ready, out_valid, value, overflow, busy
    );

    modport slave (
        input  start, in_valid, Pixels, Weights, out_ready,
        output in_ready, out_valid, value, overflow, busy
    );
endinterface

// File: rtl/dot_product_acc.sv
// Streaming signed fixed-point dot product with per-beat saturating accumulation.
// Result 3 cycles after the last accepted beat; held under out_valid until out_ready.
module dot_product_acc #(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int LANES       = 4,
    parameter int PIXEL_N     = 785
) (
    input  logic              clk,
    input  logic              GlobalReset,
    dot_product_acc_if.slave  bus
);
    localparam int BEATS      = (PIXEL_N + LANES - 1) / LANES;
    localparam int LAST_LANES = PIXEL_N - (BEATS - 1) * LANES;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SUM_W      = WEIGHT_SIZE + $clog2(LANES);
    localparam int ADD_W      = ((VAL_SIZE > SUM_W) ? VAL_SIZE : SUM_W) + 1;
    localparam int MUL_W      = WEIGHT_SIZE + PIXEL_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [CNT_W-1:0]               beat_cnt;
    logic [1:0]                     drain_cnt;
    logic                           accept;
    logic                           last_beat;
    logic                           start_take;

    logic signed [WEIGHT_SIZE-1:0]  prod_nxt [LANES];
    logic signed [WEIGHT_SIZE-1:0]  prod_dat [LANES];
    logic                           prod_vld;
    logic signed [SUM_W-1:0]        lane_sum;
    logic signed [SUM_W-1:0]        sum_dat;
    logic                           sum_vld;

    logic signed [VAL_SIZE-1:0]     acc;
    logic                           ovf;
    logic signed [ADD_W-1:0]        acc_sum;
    logic signed [ADD_W-1:0]        sat_max;
    logic signed [ADD_W-1:0]        sat_min;
    logic                           sat_hi;
    logic                           sat_lo;
    logic signed [VAL_SIZE-1:0]     acc_nxt;

    assign accept     = bus.in_valid && (state == ACCUM);
    assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
    assign start_take = (state == IDLE) && bus.start;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)                state_nxt = ACCUM;
            ACCUM:   if (accept && last_beat)      state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2)        state_nxt = OUT;
            OUT:     if (bus.out_ready)            state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE:    bus.busy      = 1'b0;
            ACCUM:   bus.in_ready  = 1'b1;
            OUT:     bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_take) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // ---------------- stage 1: per-lane products ----------------
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [MUL_W-1:0] w_ext;
        logic signed [MUL_W-1:0] p_ext;
        logic signed [MUL_W-1:0] full;
        logic                    unused_bits;

        assign w_ext = MUL_W'($signed(bus.Weights[j*WEIGHT_SIZE +: WEIGHT_SIZE]));
        assign p_ext = MUL_W'({1'b0, bus.Pixels[j*PIXEL_SIZE +: PIXEL_SIZE]});
        assign full  = w_ext * p_ext;
        // Taking bits above the fraction is the floor shift; the product always fits WEIGHT_SIZE.
        assign prod_nxt[j] = (last_beat && (j >= LAST_LANES)) ? '0
                                                               : full[PIXEL_SIZE +: WEIGHT_SIZE];
        assign unused_bits = ^{full[PIXEL_SIZE-1:0], full[MUL_W-1]};
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            prod_vld <= 1'b0;
            prod_dat <= '{default: '0};
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod_dat <= prod_nxt;
            end
        end
    end

    // ---------------- stage 2: lane sum ----------------
    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + SUM_W'(prod_dat[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            sum_vld <= 1'b0;
            sum_dat <= '0;
        end else begin
            sum_vld <= prod_vld;
            if (prod_vld) begin
                sum_dat <= lane_sum;
            end
        end
    end

    // ---------------- stage 3: saturating accumulate ----------------
    assign sat_max = {{(ADD_W - VAL_SIZE + 1){1'b0}}, {(VAL_SIZE - 1){1'b1}}};
    assign sat_min = {{(ADD_W - VAL_SIZE + 1){1'b1}}, {(VAL_SIZE - 1){1'b0}}};
    assign acc_sum = ADD_W'(acc) + ADD_W'(sum_dat);
    assign sat_hi  = (acc_sum > sat_max);
    assign sat_lo  = (acc_sum < sat_min);
    assign acc_nxt = sat_hi ? sat_max[VAL_SIZE-1:0] :
                     sat_lo ? sat_min[VAL_SIZE-1:0] :
                              acc_sum[VAL_SIZE-1:0];

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (start_take) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (sum_vld) begin
            acc <= acc_nxt;
            if (sat_hi || sat_lo) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.value    = acc;
    assign bus.overflow = ovf;
endmodule
